// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, SR/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // SR fields
    localparam int unsigned SR_IM_LSB  = 10;
    localparam int unsigned SR_EXL_BIT = 1;
    localparam int unsigned SR_IE_BIT  = 0;

    // Cause fields
    localparam int unsigned CAUSE_BD_BIT  = 31;
    localparam int unsigned CAUSE_IP_LSB  = 10;
    localparam int unsigned CAUSE_EXC_LSB = 2;

endpackage

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId with mfc0/mtc0/eret support.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h0000_2019
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PCIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic        BDIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Interrupt,
    output logic [31:0] HandlerPC,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] victim;
    logic [31:0] epc_entry;

    // Request terms use live HWInt so an interrupt is taken without sample latency
    always_comb begin
        int_req   = ie_q & ~exl_q & (|(HWInt & im_q));
        exc_req   = ~exl_q & (ExcCodeIn != 5'd0);
        Interrupt = int_req | exc_req;
        HandlerPC = HANDLER_ADDR;
        EPCOut    = epc_q;
        victim    = PCIn - 32'd4;
        epc_entry = (BDIn ? victim - 32'd4 : victim) & 32'hFFFF_FFFC;
    end

    // mfc0 read mux; shows pre-edge state only
    always_comb begin
        DOut = '0;
        unique case (A1)
            CP0_SR: begin
                DOut[SR_IM_LSB +: 6] = im_q;
                DOut[SR_EXL_BIT]     = exl_q;
                DOut[SR_IE_BIT]      = ie_q;
            end
            CP0_CAUSE: begin
                DOut[CAUSE_BD_BIT]        = bd_q;
                DOut[CAUSE_IP_LSB +: 6]   = ip_q;
                DOut[CAUSE_EXC_LSB +: 5]  = exc_q;
            end
            CP0_EPC:  DOut = epc_q;
            CP0_PRID: DOut = PRID_VAL;
            default:  DOut = '0;
        endcase
    end

    // Next-state for SR, Cause and EPC; entry discards any same-cycle mtc0.
    // mtc0 SR and eret in one cycle: the write lands first, then eret clears EXL.
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        if (Interrupt) begin
            exl_d = 1'b1;
            bd_d  = BDIn;
            exc_d = int_req ? EXC_INT : ExcCodeIn;
            epc_d = epc_entry;
        end else begin
            if (WE && A2 == CP0_SR) begin
                im_d  = DIn[SR_IM_LSB +: 6];
                exl_d = DIn[SR_EXL_BIT];
                ie_d  = DIn[SR_IE_BIT];
            end
            if (WE && A2 == CP0_EPC) begin
                epc_d = {DIn[31:2], 2'b00};
            end
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    // SR register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
        end
    end

    // Cause register; IP samples HWInt every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
        end else begin
            bd_q  <= bd_d;
            ip_q  <= HWInt;
            exc_q <= exc_d;
        end
    end

    // EPC register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit.
`timescale 1ns/1ps
module tb_cp0_exc_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PCIn;
    logic [4:0]  ExcCodeIn;
    logic        BDIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Interrupt;
    logic [31:0] HandlerPC;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    int checks = 0;
    int errors = 0;

    cp0_exc_unit #(
        .HANDLER_ADDR(32'h0000_4180),
        .PRID_VAL    (32'h0000_2019)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .WE        (WE),
        .PCIn      (PCIn),
        .ExcCodeIn (ExcCodeIn),
        .BDIn      (BDIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .Interrupt (Interrupt),
        .HandlerPC (HandlerPC),
        .EPCOut    (EPCOut),
        .DOut      (DOut)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        A1 = a;
        #1;
        check(tag, DOut, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = '0; WE = 1'b0;
        PCIn = '0; ExcCodeIn = '0; BDIn = 1'b0; HWInt = '0; EXLClr = 1'b0;
        step();
        step();
        reset = 1'b1;

        // Load non-zero state, then assert reset mid-cycle
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03;
        step();
        A2 = 5'd14; DIn = 32'h0000_0100;
        step();
        WE = 1'b0;
        rd(5'd12, "pre_reset_sr", 32'h0000_FC03);
        reset = 1'b0;
        #1;
        rd(5'd12, "reset_sr", 32'h0);
        rd(5'd13, "reset_cause", 32'h0);
        rd(5'd14, "reset_epc", 32'h0);
        rd(5'd15, "reset_prid", 32'h0000_2019);
        rd(5'd3,  "reset_unmapped", 32'h0);
        check("reset_int", {31'd0, Interrupt}, 32'h0);
        check("reset_epcout", EPCOut, 32'h0);
        check("handler_pc", HandlerPC, 32'h0000_4180);
        step();
        reset = 1'b1;

        // mtc0 SR=0x401; not visible until next cycle
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        rd(5'd12, "sr_no_bypass", 32'h0);
        step();
        WE = 1'b0;
        rd(5'd12, "sr_written", 32'h0000_0401);

        // Overflow in memory stage
        ExcCodeIn = 5'd12; PCIn = 32'h0000_3010; BDIn = 1'b0;
        #1;
        check("ov_int", {31'd0, Interrupt}, 32'h1);
        step();
        check("ov_int_masked", {31'd0, Interrupt}, 32'h0);
        ExcCodeIn = 5'd0;
        check("ov_epcout", EPCOut, 32'h0000_300C);
        rd(5'd13, "ov_cause", 32'h0000_0030);
        rd(5'd12, "ov_sr_exl", 32'h0000_0403);

        // eret
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;
        rd(5'd12, "eret_sr", 32'h0000_0401);
        rd(5'd14, "eret_epc_kept", 32'h0000_300C);

        // Delay-slot fault
        ExcCodeIn = 5'd4; PCIn = 32'h0000_3024; BDIn = 1'b1;
        #1;
        check("bd_int", {31'd0, Interrupt}, 32'h1);
        step();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        check("bd_epcout", EPCOut, 32'h0000_301C);
        rd(5'd13, "bd_cause", 32'h8000_0010);
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;

        // Interrupt beats exception; same-cycle mtc0 EPC dropped
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        step();
        HWInt = 6'b000100; ExcCodeIn = 5'd10; PCIn = 32'h0000_3040; BDIn = 1'b0;
        A2 = 5'd14; DIn = 32'h0000_1234;
        #1;
        check("prio_int", {31'd0, Interrupt}, 32'h1);
        step();
        WE = 1'b0; ExcCodeIn = 5'd0;
        check("prio_epc", EPCOut, 32'h0000_303C);
        rd(5'd13, "prio_cause", 32'h0000_1000);
        rd(5'd12, "prio_sr", 32'h0000_FC03);

        // Masking while EXL=1, then eret unmasks
        HWInt = 6'b111111;
        #1;
        check("mask_int", {31'd0, Interrupt}, 32'h0);
        step();
        rd(5'd13, "mask_cause_ip", 32'h0000_FC00);
        EXLClr = 1'b1;
        #1;
        check("mask_int_eret_cycle", {31'd0, Interrupt}, 32'h0);
        step();
        EXLClr = 1'b0;
        #1;
        check("unmask_int", {31'd0, Interrupt}, 32'h1);
        rd(5'd12, "unmask_sr", 32'h0000_FC01);
        HWInt = 6'b000000;
        #1;
        check("unmask_int_drop", {31'd0, Interrupt}, 32'h0);
        step();

        // mtc0 EPC low bits forced; Cause and PRId writes ignored
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3007;
        step();
        check("mtc0_epcout", EPCOut, 32'h0000_3004);
        rd(5'd13, "cause_before", 32'h0);
        A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        step();
        A2 = 5'd15;
        step();
        WE = 1'b0;
        rd(5'd13, "cause_ignored", 32'h0);
        rd(5'd15, "prid_ignored", 32'h0000_2019);
        rd(5'd16, "unmapped16", 32'h0);

        // mtc0 SR setting EXL together with eret: EXL ends 0
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403; EXLClr = 1'b1;
        step();
        WE = 1'b0; EXLClr = 1'b0;
        rd(5'd12, "we_eret_sr", 32'h0000_0401);

        // EXL set by mtc0 masks a synchronous exception
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403;
        step();
        WE = 1'b0;
        ExcCodeIn = 5'd5;
        #1;
        check("exl_mask_exc", {31'd0, Interrupt}, 32'h0);
        step();
        ExcCodeIn = 5'd0;
        rd(5'd14, "exl_mask_epc", 32'h0000_3004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
